// File: rtl/interp_pkg.sv
// interp_pkg: shared widths, FSM states and tag type for the
// stereo two-tap interpolation MAC scheduler.
package interp_pkg;

  localparam int SAMPLE_W = 24;
  localparam int COEF_W   = 16;
  localparam int PROD_W   = 40;
  localparam int ACC_W    = 41;
  localparam int OUT_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic valid;
    logic is_right;
  } tag_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp a wide channel sum into the signed output range.
  function automatic logic signed [OUT_W-1:0] sat32(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [OUT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/interp_mac_scheduler_tag_pipe.sv
// interp_tag_pipe: tag delay line that tracks products through the
// external multiplier; advances with the multiplier clock enable.
module interp_tag_pipe
  import interp_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce_i,
  input  logic flush_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  // Shift tags in lockstep with the multiplier; flush drops all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (ce_i) begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/interp_mac_scheduler.sv
// interp_mac_scheduler: time-shares one pipelined 24x16 multiplier
// across both channels of a two-tap linear interpolator.
module interp_mac_scheduler
  import interp_pkg::*;
#(
  parameter int MULT_LAT  = 3,
  parameter int OUT_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       start,
  output logic                       ready,
  input  logic signed [SAMPLE_W-1:0] l_s0,
  input  logic signed [SAMPLE_W-1:0] l_s1,
  input  logic signed [SAMPLE_W-1:0] r_s0,
  input  logic signed [SAMPLE_W-1:0] r_s1,
  input  logic        [COEF_W-1:0]   coef0,
  input  logic        [COEF_W-1:0]   coef1,
  output logic                       mult_ce,
  output logic        [COEF_W-1:0]   mult_a,
  output logic signed [SAMPLE_W-1:0] mult_b,
  input  logic signed [PROD_W-1:0]   mult_p,
  output logic                       dout_valid,
  output logic signed [OUT_W-1:0]    l_data_out,
  output logic signed [OUT_W-1:0]    r_data_out,
  output logic                       overrun
);

  localparam int DW = $clog2(MULT_LAT + 1);

  state_e state_q;
  logic [1:0] idx_q;
  logic [DW-1:0] drain_q;

  logic signed [SAMPLE_W-1:0] ls0_q, ls1_q;
  logic signed [SAMPLE_W-1:0] rs0_q, rs1_q;
  logic [COEF_W-1:0] c0_q, c1_q;

  logic signed [ACC_W-1:0] l_acc_q, r_acc_q;
  logic signed [ACC_W-1:0] l_acc_d, r_acc_d;
  logic signed [ACC_W-1:0] l_sh, r_sh;

  logic signed [OUT_W-1:0] l_out_q, r_out_q;
  logic dv_q, ovr_q;

  tag_t tag_in, tag_out;

  assign ready      = (state_q == IDLE);
  assign mult_ce    = (state_q == ISSUE) || (state_q == DRAIN);
  assign dout_valid = dv_q;
  assign overrun    = ovr_q;
  assign l_data_out = l_out_q;
  assign r_data_out = r_out_q;

  // Select operand pair and channel tag for the current issue slot.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    tag_in = '0;
    if (state_q == ISSUE) begin
      unique case (1'b1)
        idx_q == 2'd0: begin
          mult_a = c0_q;
          mult_b = ls0_q;
          tag_in = '{valid: 1'b1, is_right: 1'b0};
        end
        idx_q == 2'd1: begin
          mult_a = c1_q;
          mult_b = ls1_q;
          tag_in = '{valid: 1'b1, is_right: 1'b0};
        end
        idx_q == 2'd2: begin
          mult_a = c0_q;
          mult_b = rs0_q;
          tag_in = '{valid: 1'b1, is_right: 1'b1};
        end
        idx_q == 2'd3: begin
          mult_a = c1_q;
          mult_b = rs1_q;
          tag_in = '{valid: 1'b1, is_right: 1'b1};
        end
      endcase
    end
  end

  interp_tag_pipe #(
    .DEPTH(MULT_LAT)
  ) u_tags (
    .clk    (clk),
    .reset_n(reset_n),
    .ce_i   (mult_ce),
    .flush_i(!enable),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  // Fold the product leaving the multiplier into its channel sum.
  always_comb begin
    l_acc_d = l_acc_q;
    r_acc_d = r_acc_q;
    if (mult_ce && tag_out.valid) begin
      if (tag_out.is_right) begin
        r_acc_d = r_acc_q + {mult_p[PROD_W-1], mult_p};
      end else begin
        l_acc_d = l_acc_q + {mult_p[PROD_W-1], mult_p};
      end
    end
  end

  assign l_sh = l_acc_d >>> OUT_SHIFT;
  assign r_sh = r_acc_d >>> OUT_SHIFT;

  // Sequencer: capture, four issues, pipeline drain, result strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      ls0_q   <= '0;
      ls1_q   <= '0;
      rs0_q   <= '0;
      rs1_q   <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      l_acc_q <= '0;
      r_acc_q <= '0;
      l_out_q <= '0;
      r_out_q <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dv_q    <= 1'b0;
      ovr_q   <= start && (state_q != IDLE);
      l_acc_q <= l_acc_d;
      r_acc_q <= r_acc_d;
      if (!enable) begin
        state_q <= IDLE;
        idx_q   <= '0;
        drain_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              ls0_q   <= l_s0;
              ls1_q   <= l_s1;
              rs0_q   <= r_s0;
              rs1_q   <= r_s1;
              c0_q    <= coef0;
              c1_q    <= coef1;
              l_acc_q <= '0;
              r_acc_q <= '0;
              idx_q   <= '0;
              state_q <= ISSUE;
            end
          end
          ISSUE: begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              drain_q <= '0;
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (drain_q == DW'(MULT_LAT - 1)) begin
              l_out_q <= sat32(l_sh);
              r_out_q <= sat32(r_sh);
              dv_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              drain_q <= drain_q + DW'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interp_mac_scheduler.sv
// tb_interp_mac_scheduler: directed vectors with a queue scoreboard
// and behavioural multipliers for two scheduler instances.
module tb_interp_mac_scheduler;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic en2 = 1'b0;
  logic start = 1'b0;
  logic signed [23:0] l_s0 = '0, l_s1 = '0;
  logic signed [23:0] r_s0 = '0, r_s1 = '0;
  logic [15:0] coef0 = '0, coef1 = '0;

  logic ready1, ce1, dv1, ov1;
  logic [15:0] a1;
  logic signed [23:0] b1;
  logic signed [39:0] p1;
  logic signed [31:0] lo1, ro1;

  logic ready2, ce2, dv2, ov2;
  logic [15:0] a2;
  logic signed [23:0] b2;
  logic signed [39:0] p2;
  logic signed [31:0] lo2, ro2;

  interp_mac_scheduler #(.MULT_LAT(LAT), .OUT_SHIFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .start(start), .ready(ready1),
    .l_s0(l_s0), .l_s1(l_s1), .r_s0(r_s0), .r_s1(r_s1),
    .coef0(coef0), .coef1(coef1),
    .mult_ce(ce1), .mult_a(a1), .mult_b(b1), .mult_p(p1),
    .dout_valid(dv1), .l_data_out(lo1), .r_data_out(ro1),
    .overrun(ov1)
  );

  interp_mac_scheduler #(.MULT_LAT(LAT), .OUT_SHIFT(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(en2),
    .start(start), .ready(ready2),
    .l_s0(l_s0), .l_s1(l_s1), .r_s0(r_s0), .r_s1(r_s1),
    .coef0(coef0), .coef1(coef1),
    .mult_ce(ce2), .mult_a(a2), .mult_b(b2), .mult_p(p2),
    .dout_valid(dv2), .l_data_out(lo2), .r_data_out(ro2),
    .overrun(ov2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [39:0] mp1 [LAT];
  logic signed [39:0] mp2 [LAT];
  initial begin
    for (int i = 0; i < LAT; i++) begin
      mp1[i] = '0;
      mp2[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (ce1) begin
      mp1[0] <= $signed(b1) * $signed({1'b0, a1});
      for (int i = 1; i < LAT; i++) mp1[i] <= mp1[i-1];
    end
    if (ce2) begin
      mp2[0] <= $signed(b2) * $signed({1'b0, a2});
      for (int i = 1; i < LAT; i++) mp2[i] <= mp2[i-1];
    end
  end
  assign p1 = mp1[LAT-1];
  assign p2 = mp2[LAT-1];

  typedef struct {
    logic signed [31:0] l;
    logic signed [31:0] r;
    int due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int n_vec = 0;
  int n_err = 0;
  int ov_cnt1 = 0;

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && ov1) ov_cnt1++;
  end

  always @(negedge clk) begin
    if (reset_n && dv1) begin
      exp_t e;
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut1 unexpected dout_valid at cycle %0d", cyc);
      end else begin
        e = q1.pop_front();
        chk("dut1 l_data_out", lo1, e.l);
        chk("dut1 r_data_out", ro1, e.r);
        chk("dut1 dout_valid cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && dv2) begin
      exp_t e;
      if (q2.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut2 unexpected dout_valid at cycle %0d", cyc);
      end else begin
        e = q2.pop_front();
        chk("dut2 l_data_out", lo2, e.l);
        chk("dut2 r_data_out", ro2, e.r);
        chk("dut2 dout_valid cycle", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic signed [23:0] l0, l1, r0, r1,
                       input logic [15:0] c0, c1,
                       input bit push1,
                       input logic signed [31:0] el, er,
                       input bit push2,
                       input logic signed [31:0] el2, er2);
    step();
    l_s0 = l0; l_s1 = l1; r_s0 = r0; r_s1 = r1;
    coef0 = c0; coef1 = c1;
    start = 1'b1;
    if (push1) q1.push_back('{l: el, r: er, due: cyc + 5 + LAT});
    if (push2) q2.push_back('{l: el2, r: er2, due: cyc + 5 + LAT});
    step();
    start = 1'b0;
    l_s0 = 24'sh123456; l_s1 = -24'sd77;
    r_s0 = 24'sh3ABCDE; r_s1 = 24'sd9;
    coef0 = 16'hBEEF; coef1 = 16'h1234;
  endtask

  task automatic wait_ready(output int lows);
    lows = 0;
    while (!ready1 && lows < 100) begin
      step();
      lows++;
    end
    if (lows >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL ready timeout: got 0 expected 1");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int lows;
  int ov0;

  initial begin
    step();
    step();
    chk("reset dout_valid", dv1, 0);
    chk("reset overrun", ov1, 0);
    chk("reset mult_ce", ce1, 0);
    chk("reset mult_a", a1, 0);
    chk("reset mult_b", b1, 0);
    chk("reset l_data_out", lo1, 0);
    chk("reset r_data_out", ro1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;
    step();
    chk("ready after reset", ready1, 1);

    // basic interpolation, inputs scrambled after start
    issue(24'sd1000, 24'sd2000, -24'sd500, 24'sd300, 16'd411, 16'd100,
          1, 32'sd611000, -32'sd175500, 0, 0, 0);
    chk("ready low after accept", ready1, 0);
    wait_ready(lows);
    chk("ready low cycles", lows, 8);

    // saturation, also on the OUT_SHIFT=1 instance
    en2 = 1'b1;
    issue(24'sh7FFFFF, 24'sh7FFFFF, -24'sd8388608, -24'sd8388608,
          16'd511, 16'd0,
          1, 32'sh7FFFFFFF, 32'sh80000000,
          1, 32'sd2143289088, -32'sd2143289344);
    wait_ready(lows);
    step();
    en2 = 1'b0;

    // overrun: second start at cycle 3 of the operation
    ov0 = ov_cnt1;
    issue(24'sd1000, 24'sd2000, -24'sd500, 24'sd300, 16'd411, 16'd100,
          1, 32'sd611000, -32'sd175500, 0, 0, 0);
    step();
    step();
    chk("overrun idle before restart", ov1, 0);
    l_s0 = 24'sd5; coef0 = 16'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("overrun pulse", ov1, 1);
    wait_ready(lows);
    step();
    chk("overrun pulse count", ov_cnt1 - ov0, 1);

    // enable dropped during DRAIN
    issue(24'sd111, 24'sd222, 24'sd333, 24'sd444, 16'd10, 16'd20,
          0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step();
    enable = 1'b0;
    step();
    chk("abort mult_ce", ce1, 0);
    chk("abort ready", ready1, 1);
    chk("abort l held", lo1, 32'sd611000);
    chk("abort r held", ro1, -32'sd175500);
    enable = 1'b1;
    for (int k = 0; k < 12; k++) step();
    issue(-24'sd1234, 24'sd5678, 24'sd1000, -24'sd8388608,
          16'd65535, 16'd1,
          1, -32'sd80864512, 32'sd57146392, 0, 0, 0);
    wait_ready(lows);
    chk("ready low cycles after abort", lows, 8);

    // asynchronous reset in the middle of ISSUE
    issue(24'sd4000, 24'sd4000, 24'sd4000, 24'sd4000,
          16'd3, 16'd3, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset dout_valid", dv1, 0);
    chk("midreset overrun", ov1, 0);
    chk("midreset mult_ce", ce1, 0);
    chk("midreset mult_a", a1, 0);
    chk("midreset mult_b", b1, 0);
    chk("midreset l_data_out", lo1, 0);
    chk("midreset r_data_out", ro1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("ready after midreset", ready1, 1);
    issue(-24'sd8388608, 24'sd8388607, 24'sd3, 24'sd5,
          16'd65535, 16'd65535,
          1, -32'sd65535, 32'sd524280, 0, 0, 0);
    wait_ready(lows);

    // back-to-back requests
    issue(24'sd1000, 24'sd2000, -24'sd500, 24'sd300, 16'd411, 16'd100,
          1, 32'sd611000, -32'sd175500, 0, 0, 0);
    wait_ready(lows);
    issue(-24'sd100, -24'sd200, 24'sh7FFFFF, 24'sd1, 16'd0, 16'd65535,
          1, -32'sd13107000, 32'sd65535, 0, 0, 0);
    wait_ready(lows);

    for (int k = 0; k < 60 && (q1.size() != 0 || q2.size() != 0); k++)
      step();
    chk("scoreboard1 drained", q1.size(), 0);
    chk("scoreboard2 drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
